// File: rtl/bandwidth_copy_engine.sv
// Memory-copy worker for the 1-read/1-write bandwidth kernel: streams n words
// from the read half of a buffer and/or into its write half, ap_ctrl_hs started.
module bandwidth_copy_engine #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [63:0]       chan,
  input  logic [63:0]       flags,
  input  logic [63:0]       n,
  output logic              rd_addr_valid,
  input  logic              rd_addr_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data_valid,
  output logic              rd_data_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_addr_valid,
  input  logic              wr_addr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data_valid,
  input  logic              wr_data_ready,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_resp_valid,
  output logic              wr_resp_ready,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a raised valid keeps its payload stable until that edge.

  localparam int          LANES = DATA_W / 64;
  localparam logic [63:0] BYTES = 64'(DATA_W / 8);
  localparam logic [63:0] MAX_OUT = 64'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] chan_q;
  logic [63:0]       n_q;
  logic              rd_en_q, wr_en_q;
  logic [63:0]       rd_issued, rd_recv, wr_issued, wr_sent, wr_acked;
  logic [63:0]       rd_recv_nx, wr_sent_nx, wr_acked_nx;
  logic              run, copy_mode;
  logic              rd_addr_fire, rd_data_fire, wr_addr_fire, wr_data_fire, ack_fire;
  logic              rd_complete, wr_complete;

  assign fsm_state = state_q;
  assign run       = (state_q == S_RUN);
  assign copy_mode = rd_en_q & wr_en_q;

  assign rd_addr_valid = run & rd_en_q & (rd_issued < n_q) & ((rd_issued - rd_recv) < MAX_OUT);
  assign wr_addr_valid = run & wr_en_q & (wr_issued < n_q) & ((wr_issued - wr_acked) < MAX_OUT);
  assign rd_addr = chan_q + ADDR_W'(rd_issued * BYTES);
  assign wr_addr = chan_q + ADDR_W'((n_q + wr_issued) * BYTES);
  assign wr_resp_ready = run & wr_en_q;

  // Copy mode is a straight wire from the read return into the write data channel.
  always_comb begin
    rd_data_ready = 1'b0;
    wr_data_valid = 1'b0;
    wr_data       = {LANES{wr_sent}};
    if (run) begin
      if (copy_mode) begin
        rd_data_ready = wr_data_ready & (rd_recv < n_q);
        wr_data_valid = rd_data_valid & (rd_recv < n_q);
        wr_data       = rd_data;
      end else if (rd_en_q) begin
        rd_data_ready = (rd_recv < n_q);
      end else if (wr_en_q) begin
        wr_data_valid = (wr_sent < n_q);
      end
    end
  end

  assign rd_addr_fire = rd_addr_valid & rd_addr_ready;
  assign rd_data_fire = rd_data_valid & rd_data_ready;
  assign wr_addr_fire = wr_addr_valid & wr_addr_ready;
  assign wr_data_fire = wr_data_valid & wr_data_ready;
  assign ack_fire     = wr_resp_valid & wr_resp_ready & (wr_acked < n_q);

  assign rd_recv_nx  = rd_recv + 64'(rd_data_fire);
  assign wr_sent_nx  = wr_sent + 64'(wr_data_fire);
  assign wr_acked_nx = wr_acked + 64'(ack_fire);

  // Completion looks at post-handshake counts so ap_done follows the last transfer directly.
  assign rd_complete = ~rd_en_q | (rd_recv_nx == n_q);
  assign wr_complete = ~wr_en_q | ((wr_sent_nx == n_q) & (wr_acked_nx == n_q));

  always_comb begin
    state_d  = state_q;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_idle  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle  = 1'b1;
        ap_ready = ap_start;
        if (ap_start) begin
          state_d = ((n == 64'd0) || (flags[1:0] == 2'b00)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_complete && wr_complete) state_d = S_DONE;
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      chan_q    <= '0;
      n_q       <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_issued <= '0;
      rd_recv   <= '0;
      wr_issued <= '0;
      wr_sent   <= '0;
      wr_acked  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ap_start) begin
        chan_q    <= chan[ADDR_W-1:0];
        n_q       <= n;
        rd_en_q   <= flags[0];
        wr_en_q   <= flags[1];
        rd_issued <= '0;
        rd_recv   <= '0;
        wr_issued <= '0;
        wr_sent   <= '0;
        wr_acked  <= '0;
      end else if (run) begin
        rd_issued <= rd_issued + 64'(rd_addr_fire);
        rd_recv   <= rd_recv_nx;
        wr_issued <= wr_issued + 64'(wr_addr_fire);
        wr_sent   <= wr_sent_nx;
        wr_acked  <= wr_acked_nx;
      end
    end
  end

endmodule

// File: tb/tb_bandwidth_copy_engine.sv
// Bench for bandwidth_copy_engine: memory responder, handshake monitor and
// per-job scoreboard built from the buffer layout rules.
module tb_bandwidth_copy_engine;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int LANES  = DATA_W / 64;
  localparam logic [63:0] BYTES = 64'd64;

  logic ap_clk, ap_rst, ap_start, ap_ready, ap_done, ap_idle;
  logic [63:0] chan, flags, n;
  logic rd_addr_valid, rd_addr_ready, rd_data_valid, rd_data_ready;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic wr_addr_valid, wr_addr_ready, wr_data_valid, wr_data_ready, wr_resp_valid, wr_resp_ready;
  logic [1:0] fsm_state;

  bandwidth_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .chan(chan), .flags(flags), .n(n),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .wr_addr_valid(wr_addr_valid), .wr_addr_ready(wr_addr_ready), .wr_addr(wr_addr),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  // clock / cycle counter
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end
  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  function automatic logic [DATA_W-1:0] mem_word(input logic [63:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[64*i +: 64] = (a * 64'(i + 5)) ^ 64'h5a5a_0f0f_c3c3_9696;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] rep(input logic [63:0] v);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[64*i +: 64] = v;
    return w;
  endfunction

  // monitor state
  logic [63:0] rd_addr_seen[$], wr_addr_seen[$], rd_pend[$];
  logic [DATA_W-1:0] wr_data_seen[$];
  int n_rd_addr, n_rd_data, n_wr_addr, n_wr_data, n_ack;
  int max_rd_out, max_wr_out, ready_pulses, done_pulses, stab_err, any_rd, any_wr;
  longint last_hs_cyc;
  bit rd_fire, resp_fire;
  bit p_rav, p_wav, p_wdv;
  logic [63:0] p_ra, p_wa;
  logic [DATA_W-1:0] p_wd;
  bit bp;
  int rd_hold_cycles;

  task automatic clear_monitor();
    rd_addr_seen.delete(); wr_addr_seen.delete(); rd_pend.delete(); wr_data_seen.delete();
    n_rd_addr = 0; n_rd_data = 0; n_wr_addr = 0; n_wr_data = 0; n_ack = 0;
    max_rd_out = 0; max_wr_out = 0; ready_pulses = 0; done_pulses = 0;
    stab_err = 0; any_rd = 0; any_wr = 0; last_hs_cyc = -1;
  endtask

  // Handshakes sampled at negedge: valid&&ready here completes at the next posedge.
  initial forever begin
    @(negedge ap_clk);
    if (ap_rst) begin
      rd_fire = 0; resp_fire = 0; p_rav = 0; p_wav = 0; p_wdv = 0;
    end else begin
      rd_fire   = rd_data_valid && rd_data_ready;
      resp_fire = wr_resp_valid && wr_resp_ready;
      if (p_rav && !(rd_addr_valid && rd_addr == p_ra)) stab_err++;
      if (p_wav && !(wr_addr_valid && wr_addr == p_wa)) stab_err++;
      if (p_wdv && !(wr_data_valid && wr_data == p_wd)) stab_err++;
      if (rd_addr_valid || rd_data_ready) any_rd++;
      if (wr_addr_valid || wr_data_valid || wr_resp_ready) any_wr++;
      if (rd_addr_valid && rd_addr_ready) begin
        rd_addr_seen.push_back(rd_addr); rd_pend.push_back(rd_addr); n_rd_addr++;
      end
      if (rd_fire) begin
        if (rd_pend.size() > 0) void'(rd_pend.pop_front());
        n_rd_data++; last_hs_cyc = cyc;
      end
      if (wr_addr_valid && wr_addr_ready) begin
        wr_addr_seen.push_back(wr_addr); n_wr_addr++;
      end
      if (wr_data_valid && wr_data_ready) begin
        wr_data_seen.push_back(wr_data); n_wr_data++; last_hs_cyc = cyc;
      end
      if (resp_fire) begin
        n_ack++; last_hs_cyc = cyc;
      end
      if (n_rd_addr - n_rd_data > max_rd_out) max_rd_out = n_rd_addr - n_rd_data;
      if (n_wr_addr - n_ack > max_wr_out) max_wr_out = n_wr_addr - n_ack;
      if (ap_ready) ready_pulses++;
      if (ap_done) done_pulses++;
      p_rav = rd_addr_valid && !rd_addr_ready; p_ra = rd_addr;
      p_wav = wr_addr_valid && !wr_addr_ready; p_wa = wr_addr;
      p_wdv = wr_data_valid && !wr_data_ready; p_wd = wr_data;
    end
  end

  // memory responder driver
  initial forever begin
    int avail;
    @(posedge ap_clk);
    #1;
    if (ap_rst) begin
      rd_pend.delete();
      rd_addr_ready = 0; rd_data_valid = 0; rd_data = '0;
      wr_addr_ready = 0; wr_data_ready = 0; wr_resp_valid = 0;
    end else begin
      rd_addr_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_addr_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rd_hold_cycles > 0) rd_hold_cycles--;
      if (!rd_data_valid || rd_fire) begin
        if (rd_pend.size() > 0 && rd_hold_cycles == 0 && (!bp || $urandom_range(0, 3) != 0)) begin
          rd_data_valid = 1; rd_data = mem_word(rd_pend[0]);
        end else begin
          rd_data_valid = 0;
        end
      end
      if (!wr_resp_valid || resp_fire) begin
        avail = ((n_wr_addr < n_wr_data) ? n_wr_addr : n_wr_data) - n_ack;
        wr_resp_valid = (avail > 0) && (!bp || $urandom_range(0, 2) != 0);
      end
    end
  end

  task automatic test_job(input logic [63:0] c, input logic [63:0] f, input logic [63:0] nn,
                          input bit use_bp, input int hold);
    logic [63:0] exp_ra[$], exp_wa[$];
    logic [DATA_W-1:0] exp_q[$];
    longint rc, dc, exp_dc;
    bit degenerate, got_done, rd_on, wr_on;
    rd_on = f[0]; wr_on = f[1];
    degenerate = (nn == 0) || (f[1:0] == 2'b00);
    dc = 0;
    if (!degenerate) begin
      for (longint i = 0; i < longint'(nn); i++) begin
        if (rd_on) exp_ra.push_back(c + 64'(i) * BYTES);
        if (wr_on) begin
          exp_wa.push_back(c + (nn + 64'(i)) * BYTES);
          exp_q.push_back(rd_on ? mem_word(c + 64'(i) * BYTES) : rep(64'(i)));
        end
      end
    end
    @(posedge ap_clk); #2;
    clear_monitor();
    bp = use_bp; rd_hold_cycles = hold;
    chan = c; flags = f; n = nn; ap_start = 1;
    @(negedge ap_clk);
    checks++;
    if (ap_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b expected 1", ap_ready); end
    rc = cyc;
    @(posedge ap_clk); #2;
    ap_start = 0;
    got_done = 0;
    for (int k = 1; k <= 4000 && !got_done; k++) begin
      @(negedge ap_clk);
      if (k == 1) begin
        checks++;
        if (ap_idle !== 1'b0) begin errors++; $display("FAIL first_cycle_idle: got %b expected 0", ap_idle); end
        if (!degenerate) begin
          checks++;
          if (rd_addr_valid !== rd_on || wr_addr_valid !== wr_on) begin
            errors++;
            $display("FAIL first_cycle_addr_valid: got rd=%b wr=%b expected rd=%b wr=%b", rd_addr_valid, wr_addr_valid, rd_on, wr_on);
          end
        end
      end
      if (ap_done) begin got_done = 1; dc = cyc; end
    end
    checks++;
    if (!got_done) begin errors++; $display("FAIL done_timeout: no ap_done within 4000 cycles (n=%0d flags=%0d)", nn, f); end
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++; $display("FAIL after_done: got idle=%b done=%b expected idle=1 done=0", ap_idle, ap_done);
    end
    checks++;
    if (ready_pulses != 1 || done_pulses != 1) begin
      errors++; $display("FAIL pulse_count: got ready=%0d done=%0d expected 1 and 1", ready_pulses, done_pulses);
    end
    exp_dc = degenerate ? rc + 1 : last_hs_cyc + 1;
    checks++;
    if (dc != exp_dc) begin errors++; $display("FAIL done_timing: got cycle %0d expected %0d", dc, exp_dc); end
    checks++;
    if (rd_addr_seen.size() != exp_ra.size() || n_rd_data != exp_ra.size()) begin
      errors++; $display("FAIL rd_count: got req=%0d ret=%0d expected %0d", rd_addr_seen.size(), n_rd_data, exp_ra.size());
    end
    for (int i = 0; i < exp_ra.size() && i < rd_addr_seen.size(); i++) begin
      checks++;
      if (rd_addr_seen[i] !== exp_ra[i]) begin errors++; $display("FAIL rd_addr[%0d]: got %h expected %h", i, rd_addr_seen[i], exp_ra[i]); end
    end
    checks++;
    if (wr_addr_seen.size() != exp_wa.size() || wr_data_seen.size() != exp_q.size() || n_ack != exp_q.size()) begin
      errors++;
      $display("FAIL wr_count: got addr=%0d data=%0d ack=%0d expected %0d", wr_addr_seen.size(), wr_data_seen.size(), n_ack, exp_q.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_seen.size(); i++) begin
      checks++;
      if (wr_addr_seen[i] !== exp_wa[i]) begin errors++; $display("FAIL wr_addr[%0d]: got %h expected %h", i, wr_addr_seen[i], exp_wa[i]); end
    end
    for (int i = 0; i < exp_q.size() && i < wr_data_seen.size(); i++) begin
      checks++;
      if (wr_data_seen[i] !== exp_q[i]) begin errors++; $display("FAIL wr_data[%0d]: got %h expected %h", i, wr_data_seen[i], exp_q[i]); end
    end
    if (!rd_on || degenerate) begin
      checks++;
      if (any_rd != 0) begin errors++; $display("FAIL rd_idle_channel: got %0d active cycles expected 0", any_rd); end
    end
    if (!wr_on || degenerate) begin
      checks++;
      if (any_wr != 0) begin errors++; $display("FAIL wr_idle_channel: got %0d active cycles expected 0", any_wr); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL payload_stable: got %0d violations expected 0", stab_err); end
    checks++;
    if (max_rd_out > 16 || max_wr_out > 16) begin
      errors++; $display("FAIL outstanding_cap: got rd=%0d wr=%0d expected <=16", max_rd_out, max_wr_out);
    end
    if (hold > 0 && rd_on && nn >= 16) begin
      checks++;
      if (max_rd_out != 16) begin errors++; $display("FAIL outstanding_full: got %0d expected 16", max_rd_out); end
    end
  endtask

  task automatic test_reset();
    ap_rst = 1; ap_start = 0; chan = 0; flags = 0; n = 0; bp = 0; rd_hold_cycles = 0;
    rd_addr_ready = 0; rd_data_valid = 0; rd_data = '0;
    wr_addr_ready = 0; wr_data_ready = 0; wr_resp_valid = 0;
    clear_monitor();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got idle=%b ready=%b done=%b expected 1 0 0", ap_idle, ap_ready, ap_done);
    end
    checks++;
    if ({rd_addr_valid, rd_data_ready, wr_addr_valid, wr_data_valid, wr_resp_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 00000", {rd_addr_valid, rd_data_ready, wr_addr_valid, wr_data_valid, wr_resp_ready});
    end
    checks++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL reset_payload: got rd_addr=%h wr_addr=%h wr_data=%h expected 0", rd_addr, wr_addr, wr_data);
    end
    ap_rst = 0;
  endtask

  task automatic test_copy();
    test_job(64'h1000, 64'd3, 64'd4, 1'b0, 0);
    test_job({$urandom, $urandom}, 64'd3, 64'($urandom_range(1, 30)), 1'b1, 0);
    test_job(64'hFFFF_FFFF_FFFF_FF80, 64'd3, 64'd4, 1'b0, 0);
  endtask

  task automatic test_read_only();
    test_job({$urandom, $urandom}, 64'd1, 64'd3, 1'b0, 0);
  endtask

  task automatic test_write_only();
    test_job(64'h0, 64'd2, 64'd2, 1'b0, 0);
    test_job({$urandom, $urandom}, 64'hFFFF_0000_0000_00F2, 64'($urandom_range(1, 30)), 1'b1, 0);
  endtask

  task automatic test_backpressure();
    test_job(64'h4_0000, 64'd3, 64'd40, 1'b0, 50);
  endtask

  task automatic test_degenerate();
    test_job(64'h2000, 64'd3, 64'd0, 1'b0, 0);
    test_job(64'h2000, 64'd0, 64'd5, 1'b0, 0);
  endtask

  task automatic test_reset_midrun();
    bit reached;
    @(posedge ap_clk); #2;
    clear_monitor();
    bp = 0; rd_hold_cycles = 0;
    chan = 64'h8000; flags = 64'd3; n = 64'd20; ap_start = 1;
    @(posedge ap_clk); #2;
    ap_start = 0;
    reached = 0;
    for (int k = 0; k < 500 && !reached; k++) begin
      @(negedge ap_clk);
      if (n_wr_data >= 5) reached = 1;
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL midrun_progress: got %0d words expected 5", n_wr_data); end
    ap_rst = 1;
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_ctrl: got idle=%b ready=%b done=%b expected 1 0 0", ap_idle, ap_ready, ap_done);
    end
    checks++;
    if ({rd_addr_valid, wr_addr_valid, wr_data_valid, rd_data_ready, wr_resp_ready} !== 5'b0) begin
      errors++;
      $display("FAIL midrun_reset_valids: got %b expected 00000", {rd_addr_valid, wr_addr_valid, wr_data_valid, rd_data_ready, wr_resp_ready});
    end
    ap_rst = 0;
    test_job(64'h9000, 64'd3, 64'd2, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      test_job({$urandom, $urandom}, 64'($urandom_range(1, 3)), 64'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_read_only();
    test_write_only();
    test_backpressure();
    test_degenerate();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
